clock_set_ctrl: RTL and testbench
=================================

Name: clock_set_ctrl

Overview:
Time-set sequencer between the strobe generator (1 Hz, 2 Hz slow-set and 8 Hz fast-set strobes) and the hours/minutes/seconds counters.
- In normal run it forwards the 1 Hz strobe as the seconds increment.
- While a set button is held it suppresses seconds and issues auto-repeat increments to the minutes or hours counter: one immediate increment, then 2 Hz, then 8 Hz after a hold threshold.
- It contains the button debouncers and the set state machine.

Parameters:
- FAST_THRESH, 4, number of slow-rate increments issued in SLOW before moving to FAST (legal range 1..255).
- DEBOUNCE_TICKS, 2, number of consecutive i_fast_set_stb samples a raw button level must differ from the debounced level before the debounced level flips (legal range 1..15).

Ports:
- i_clk, input, 1, system clock; the single clock for the block.
- i_reset, input, 1, synchronous, active-high reset.
- i_1hz_stb, input, 1, one-cycle 1 Hz strobe.
- i_slow_set_stb, input, 1, one-cycle 2 Hz strobe.
- i_fast_set_stb, input, 1, one-cycle 8 Hz strobe.
- i_set_hours, input, 1, raw hours-set button, already synchronised to i_clk, active-high.
- i_set_minutes, input, 1, raw minutes-set button, already synchronised to i_clk, active-high.
- o_sec_inc, output, 1, one-cycle seconds increment pulse.
- o_min_inc, output, 1, one-cycle minutes increment pulse.
- o_hr_inc, output, 1, one-cycle hours increment pulse.
- o_clr_sec, output, 1, one-cycle pulse that clears the seconds counter at set entry.
- o_setting, output, 1, high whenever the state is not IDLE.

Behaviour:
Outputs and reset
- All outputs are registered, with 1-cycle latency from the causing strobe or state change.
- Reset values: all outputs 0, state IDLE, debounced levels 0, debounce counters 0, slow counter 0, target = minutes.
- i_reset asserted in any state gives the reset values on the next edge. Any in-flight pulse is dropped.

Debounce (one instance per button)
- Updates only on cycles where i_fast_set_stb = 1.
- If raw level != debounced level: counter += 1. When the counter reaches DEBOUNCE_TICKS, the debounced level flips and the counter clears.
- If raw level == debounced level: counter clears.

FSM states: IDLE, FIRST, SLOW, FAST.
- IDLE
  - o_sec_inc <= i_1hz_stb.
  - If debounced hours or debounced minutes = 1: latch target (hours has priority when both are 1), go to FIRST.
- FIRST (exactly 1 cycle)
  - Emit one increment to the target.
  - Pulse o_clr_sec.
  - Clear the slow counter.
  - Go to SLOW.
- SLOW
  - On each i_slow_set_stb: emit a target increment and increment the slow counter.
  - When the counter reaches FAST_THRESH, go to FAST on that cycle.
  - The counter saturates and does not wrap.
- FAST
  - On each i_fast_set_stb: emit a target increment.
- Exit from FIRST, SLOW or FAST
  - When the debounced level of the latched target = 0, go to IDLE next cycle.
  - No increment is issued on the exit cycle.

Suppression and arbitration
- In FIRST, SLOW and FAST, i_1hz_stb is ignored and o_sec_inc = 0. This includes a 1 Hz strobe coincident with the IDLE->FIRST transition.
- The non-target button is ignored until the FSM returns to IDLE. A still-held other button then starts a new set sequence.
- At most one of o_sec_inc / o_min_inc / o_hr_inc is high in any cycle.
- Only the strobe relevant to the current state is consumed.

Optional Feature:
Macro CLOCK_SET_FAST_EN.
- Defined: the SLOW->FAST acceleration works as described above.
- Not defined: the FAST state and its transition are removed. SLOW repeats at 2 Hz indefinitely, and FAST_THRESH is unused.

Test Plan:
1. Idle run: no buttons, 5 i_1hz_stb pulses -> exactly 5 o_sec_inc pulses, each 1 cycle after its strobe. o_setting = 0, o_min_inc = o_hr_inc = 0.
2. Debounce reject: i_set_minutes high for 1 fast strobe then low -> state stays IDLE, no o_min_inc, o_setting = 0.
3. Minutes hold with defaults:
   - i_set_minutes held for 2 fast strobes -> FIRST: one o_min_inc plus one o_clr_sec.
   - Next 4 slow strobes -> 4 o_min_inc.
   - Following 8 fast strobes -> 8 o_min_inc (13 total).
   - 1 Hz strobes in this window give 0 o_sec_inc.
   - Release plus 2 fast strobes -> IDLE, o_setting = 0.
4. Both buttons debounced high on the same cycle -> target = hours: o_hr_inc only, 0 o_min_inc. After releasing hours with minutes still held -> IDLE, then a new minutes sequence begins.
5. Reset mid-FAST: assert i_reset for 1 cycle -> next cycle all outputs 0 and state IDLE. The button must re-debounce for 2 fast strobes before the next o_*_inc.
6. Build without CLOCK_SET_FAST_EN, minutes held for 20 slow strobes -> 1 + 20 o_min_inc, and no increment on any i_fast_set_stb-only cycle.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// Time-set sequencer: forwards 1 Hz as seconds, or auto-repeats minutes/hours increments while a set button is held.
// Define CLOCK_SET_FAST_EN to enable SLOW->FAST acceleration after FAST_THRESH slow increments.

module clock_set_ctrl_debounce #(
    parameter int DEBOUNCE_TICKS = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_sample_stb,
    input  logic i_raw,
    output logic o_level
);
    localparam logic [3:0] TICKS = 4'(DEBOUNCE_TICKS);

    logic       level_q, level_d;
    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (i_sample_stb) begin
            if (i_raw != level_q) begin
                if (cnt_q + 4'd1 == TICKS) begin
                    level_d = ~level_q;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end else begin
                cnt_d = 4'd0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            level_q <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_level = level_q;
endmodule

module clock_set_ctrl #(
    parameter int FAST_THRESH    = 4,
    parameter int DEBOUNCE_TICKS = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_1hz_stb,
    input  logic i_slow_set_stb,
    input  logic i_fast_set_stb,
    input  logic i_set_hours,
    input  logic i_set_minutes,
    output logic o_sec_inc,
    output logic o_min_inc,
    output logic o_hr_inc,
    output logic o_clr_sec,
    output logic o_setting
);
    localparam logic [7:0] THRESH = 8'(FAST_THRESH);

    // IDLE: run | FIRST: immediate increment | SLOW: 2 Hz repeat | FAST: 8 Hz repeat
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FIRST,
        ST_SLOW,
        ST_FAST
    } state_t;

    state_t     state_q;
    logic       tgt_hr_q;
    logic [7:0] slow_cnt_q;
    logic       sec_inc_q, min_inc_q, hr_inc_q, clr_sec_q, setting_q;

    logic deb_hr, deb_min, tgt_level;
    logic [7:0] slow_cnt_nxt;

    clock_set_ctrl_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb_hr (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_sample_stb (i_fast_set_stb),
        .i_raw        (i_set_hours),
        .o_level      (deb_hr)
    );

    clock_set_ctrl_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb_min (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_sample_stb (i_fast_set_stb),
        .i_raw        (i_set_minutes),
        .o_level      (deb_min)
    );

    assign tgt_level = tgt_hr_q ? deb_hr : deb_min;

    // Saturates at the threshold; in the non-accelerating build it simply holds there.
    assign slow_cnt_nxt = (slow_cnt_q >= THRESH) ? slow_cnt_q : slow_cnt_q + 8'd1;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            tgt_hr_q   <= 1'b0;
            slow_cnt_q <= 8'd0;
            sec_inc_q  <= 1'b0;
            min_inc_q  <= 1'b0;
            hr_inc_q   <= 1'b0;
            clr_sec_q  <= 1'b0;
            setting_q  <= 1'b0;
        end else begin
            sec_inc_q <= 1'b0;
            min_inc_q <= 1'b0;
            hr_inc_q  <= 1'b0;
            clr_sec_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (deb_hr || deb_min) begin
                        tgt_hr_q  <= deb_hr;
                        state_q   <= ST_FIRST;
                        setting_q <= 1'b1;
                    end else begin
                        sec_inc_q <= i_1hz_stb;
                    end
                end
                ST_FIRST: begin
                    if (!tgt_level) begin
                        state_q   <= ST_IDLE;
                        setting_q <= 1'b0;
                    end else begin
                        hr_inc_q   <= tgt_hr_q;
                        min_inc_q  <= ~tgt_hr_q;
                        clr_sec_q  <= 1'b1;
                        slow_cnt_q <= 8'd0;
                        state_q    <= ST_SLOW;
                    end
                end
                ST_SLOW: begin
                    if (!tgt_level) begin
                        state_q   <= ST_IDLE;
                        setting_q <= 1'b0;
                    end else if (i_slow_set_stb) begin
                        hr_inc_q   <= tgt_hr_q;
                        min_inc_q  <= ~tgt_hr_q;
                        slow_cnt_q <= slow_cnt_nxt;
`ifdef CLOCK_SET_FAST_EN
                        if (slow_cnt_nxt == THRESH) begin
                            state_q <= ST_FAST;
                        end
`endif
                    end
                end
`ifdef CLOCK_SET_FAST_EN
                ST_FAST: begin
                    if (!tgt_level) begin
                        state_q   <= ST_IDLE;
                        setting_q <= 1'b0;
                    end else if (i_fast_set_stb) begin
                        hr_inc_q  <= tgt_hr_q;
                        min_inc_q <= ~tgt_hr_q;
                    end
                end
`endif
                default: begin
                    state_q   <= ST_IDLE;
                    setting_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_sec_inc = sec_inc_q;
    assign o_min_inc = min_inc_q;
    assign o_hr_inc  = hr_inc_q;
    assign o_clr_sec = clr_sec_q;
    assign o_setting = setting_q;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl; expectations adapt to whether CLOCK_SET_FAST_EN is defined.
module tb_clock_set_ctrl;
    logic i_clk = 1'b0;
    logic i_reset = 1'b1;
    logic i_1hz_stb = 1'b0, i_slow_set_stb = 1'b0, i_fast_set_stb = 1'b0;
    logic i_set_hours = 1'b0, i_set_minutes = 1'b0;
    logic o_sec_inc, o_min_inc, o_hr_inc, o_clr_sec, o_setting;

    int total = 0;
    int bad = 0;
    int n_sec = 0, n_min = 0, n_hr = 0, n_clr = 0;
    int b_sec, b_min, b_hr, b_clr;

`ifdef CLOCK_SET_FAST_EN
    localparam int EXP_T3_RUN = 13;
    localparam int EXP_T3_REL = 2;
    localparam int EXP_T6     = 22;
`else
    localparam int EXP_T3_RUN = 5;
    localparam int EXP_T3_REL = 0;
    localparam int EXP_T6     = 21;
`endif

    clock_set_ctrl #(.FAST_THRESH(4), .DEBOUNCE_TICKS(2)) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_1hz_stb      (i_1hz_stb),
        .i_slow_set_stb (i_slow_set_stb),
        .i_fast_set_stb (i_fast_set_stb),
        .i_set_hours    (i_set_hours),
        .i_set_minutes  (i_set_minutes),
        .o_sec_inc      (o_sec_inc),
        .o_min_inc      (o_min_inc),
        .o_hr_inc       (o_hr_inc),
        .o_clr_sec      (o_clr_sec),
        .o_setting      (o_setting)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_sec_inc === 1'b1) n_sec <= n_sec + 1;
        if (o_min_inc === 1'b1) n_min <= n_min + 1;
        if (o_hr_inc === 1'b1)  n_hr  <= n_hr + 1;
        if (o_clr_sec === 1'b1) n_clr <= n_clr + 1;
    end

    task automatic cyc(input logic h, input logic s, input logic f);
        i_1hz_stb = h;
        i_slow_set_stb = s;
        i_fast_set_stb = f;
        @(posedge i_clk);
        #1;
        i_1hz_stb = 1'b0;
        i_slow_set_stb = 1'b0;
        i_fast_set_stb = 1'b0;
    endtask

    task automatic snap();
        b_sec = n_sec;
        b_min = n_min;
        b_hr  = n_hr;
        b_clr = n_clr;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        i_reset = 1'b0;
        total++;
        if ({o_sec_inc, o_min_inc, o_hr_inc, o_clr_sec, o_setting} !== 5'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=00000",
                     {o_sec_inc, o_min_inc, o_hr_inc, o_clr_sec, o_setting});
        end
    endtask

    task automatic test_idle_run();
        snap();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            total++;
            if (o_sec_inc !== 1'b1) begin
                bad++;
                $display("FAIL idle_sec_pulse[%0d] got=%b exp=1", i, o_sec_inc);
            end
            cyc(1'b0, 1'b0, 1'b0);
            total++;
            if (o_sec_inc !== 1'b0) begin
                bad++;
                $display("FAIL idle_sec_gap[%0d] got=%b exp=0", i, o_sec_inc);
            end
        end
        total++;
        if (n_sec - b_sec != 5) begin
            bad++;
            $display("FAIL idle_sec_count got=%0d exp=5", n_sec - b_sec);
        end
        total++;
        if (n_min - b_min + n_hr - b_hr != 0 || o_setting !== 1'b0) begin
            bad++;
            $display("FAIL idle_no_set got_inc=%0d got_setting=%b exp=0/0",
                     n_min - b_min + n_hr - b_hr, o_setting);
        end
    endtask

    task automatic test_debounce_reject();
        snap();
        i_set_minutes = 1'b1;
        cyc(1'b0, 1'b0, 1'b1);
        i_set_minutes = 1'b0;
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0);
        total++;
        if (n_min - b_min != 0 || o_setting !== 1'b0) begin
            bad++;
            $display("FAIL deb_reject got_min=%0d got_setting=%b exp=0/0", n_min - b_min, o_setting);
        end
    endtask

    task automatic test_minutes_hold();
        snap();
        i_set_minutes = 1'b1;
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        total++;
        if (o_setting !== 1'b0) begin
            bad++;
            $display("FAIL hold_still_idle got=%b exp=0", o_setting);
        end
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        total++;
        if (o_min_inc !== 1'b1 || o_clr_sec !== 1'b1) begin
            bad++;
            $display("FAIL hold_first got_min=%b got_clr=%b exp=1/1", o_min_inc, o_clr_sec);
        end
        cyc(1'b0, 1'b0, 1'b0);
        total++;
        if (n_min - b_min != 1 || n_clr - b_clr != 1 || o_setting !== 1'b1) begin
            bad++;
            $display("FAIL hold_first_count got_min=%0d got_clr=%0d got_setting=%b exp=1/1/1",
                     n_min - b_min, n_clr - b_clr, o_setting);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
            cyc(1'b1, 1'b0, 1'b0);
        end
        cyc(1'b0, 1'b0, 1'b0);
        total++;
        if (n_min - b_min != 5 || n_sec - b_sec != 0) begin
            bad++;
            $display("FAIL hold_slow got_min=%0d got_sec=%0d exp=5/0", n_min - b_min, n_sec - b_sec);
        end
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b0, 1'b1);
            cyc(1'b0, 1'b0, 1'b0);
        end
        total++;
        if (n_min - b_min != EXP_T3_RUN || n_hr - b_hr != 0) begin
            bad++;
            $display("FAIL hold_fast got_min=%0d got_hr=%0d exp=%0d/0",
                     n_min - b_min, n_hr - b_hr, EXP_T3_RUN);
        end
        snap();
        i_set_minutes = 1'b0;
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        total++;
        if (o_setting !== 1'b0) begin
            bad++;
            $display("FAIL hold_release_setting got=%b exp=0", o_setting);
        end
        cyc(1'b0, 1'b0, 1'b0);
        total++;
        if (n_min - b_min != EXP_T3_REL) begin
            bad++;
            $display("FAIL hold_release_count got=%0d exp=%0d", n_min - b_min, EXP_T3_REL);
        end
    endtask

    task automatic test_both_buttons();
        snap();
        i_set_hours = 1'b1;
        i_set_minutes = 1'b1;
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0);
        total++;
        if (n_hr - b_hr != 1 || n_min - b_min != 0) begin
            bad++;
            $display("FAIL both_priority got_hr=%0d got_min=%0d exp=1/0", n_hr - b_hr, n_min - b_min);
        end
        snap();
        i_set_hours = 1'b0;
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        total++;
        if (o_setting !== 1'b0) begin
            bad++;
            $display("FAIL both_back_idle got=%b exp=0", o_setting);
        end
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        total++;
        if (n_min - b_min != 1 || n_hr - b_hr != 0 || n_clr - b_clr != 1 || o_setting !== 1'b1) begin
            bad++;
            $display("FAIL both_new_min got_min=%0d got_hr=%0d got_clr=%0d got_setting=%b exp=1/0/1/1",
                     n_min - b_min, n_hr - b_hr, n_clr - b_clr, o_setting);
        end
    endtask

    task automatic test_reset_mid_set();
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        total++;
        if (o_min_inc !== 1'b1) begin
            bad++;
            $display("FAIL rst_inflight got=%b exp=1", o_min_inc);
        end
        i_reset = 1'b1;
        cyc(1'b1, 1'b0, 1'b1);
        i_reset = 1'b0;
        total++;
        if ({o_sec_inc, o_min_inc, o_hr_inc, o_clr_sec, o_setting} !== 5'b0) begin
            bad++;
            $display("FAIL rst_mid_outputs got=%b exp=00000",
                     {o_sec_inc, o_min_inc, o_hr_inc, o_clr_sec, o_setting});
        end
        snap();
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        total++;
        if (o_setting !== 1'b0 || n_min - b_min != 0) begin
            bad++;
            $display("FAIL rst_redebounce got_setting=%b got_min=%0d exp=0/0", o_setting, n_min - b_min);
        end
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        total++;
        if (n_min - b_min != 1) begin
            bad++;
            $display("FAIL rst_resume got=%0d exp=1", n_min - b_min);
        end
    endtask

    task automatic test_long_slow();
        i_set_minutes = 1'b0;
        i_reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        i_reset = 1'b0;
        snap();
        i_set_minutes = 1'b1;
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
            cyc(1'b0, 1'b0, 1'b1);
`ifndef CLOCK_SET_FAST_EN
            total++;
            if (o_min_inc !== 1'b0) begin
                bad++;
                $display("FAIL long_fast_only[%0d] got=%b exp=0", i, o_min_inc);
            end
`endif
        end
        cyc(1'b0, 1'b0, 1'b0);
        total++;
        if (n_min - b_min != EXP_T6) begin
            bad++;
            $display("FAIL long_count got=%0d exp=%0d", n_min - b_min, EXP_T6);
        end
        i_set_minutes = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle_run();
        test_debounce_reject();
        test_minutes_hold();
        test_both_buttons();
        test_reset_mid_set();
        test_long_slow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
